// File: rtl/eth_rx_cls_pkg.sv
// Shared types and constants for the MII receive classifier: FSM states,
// class candidate bits, post-SFD nibble offsets of checked fields and match values.
package eth_rx_cls_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_HDR, ST_DONE} state_t;

   typedef struct packed {
      logic arp;
      logic icmp;
      logic udp;
   } cls_t;

   localparam int MAC_OFS    = 0;
   localparam int ETYPE_OFS  = 24;
   localparam int IHL_OFS    = 28;
   localparam int PROTO_OFS  = 46;
   localparam int IPDST_OFS  = 60;
   localparam int ICMPT_OFS  = 68;
   localparam int UDPDP_OFS  = 72;
   localparam int ARPTIP_OFS = 76;
   localparam int DECIDE     = 83;
   localparam int PRE_MAX    = 24;

   localparam logic [15:0] ETYPE_ARP     = 16'h0806;
   localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
   localparam logic [7:0]  PROTO_ICMP    = 8'h01;
   localparam logic [7:0]  PROTO_UDP     = 8'h11;
   localparam logic [7:0]  IPV4_VIHL     = 8'h45;
   localparam logic [7:0]  ICMP_ECHO_REQ = 8'h08;

   // Nibble k of a big-endian field of nbytes bytes, in MII order (low nibble first).
   function automatic logic [3:0] field_nib(input logic [47:0] field, input int nbytes, input int k);
      logic [47:0] sh;
      sh = field >> ((nbytes - 1 - k / 2) * 8 + (k % 2) * 4);
      return sh[3:0];
   endfunction

endpackage

// File: rtl/eth_nibble_delay.sv
// Fixed-length shift line that delays a W-bit sample by DEPTH clock cycles.
module eth_nibble_delay #(
   parameter int DEPTH = 101,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] sample,
   output logic [W-1:0] delayed
);

   logic [DEPTH-1:0][W-1:0] line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line <= '0;
      end else begin
         line <= {line[DEPTH-2:0], sample};
      end
   end

   assign delayed = line[DEPTH-1];

endmodule

// File: rtl/eth_rx_classifier.sv
// MII RX classifier: locks on the SFD, flags ARP / ICMP echo / UDP-to-port and
// delays the stream. Define ETH_RX_CLS_STATS_EN to build the frame counters.
module eth_rx_classifier
   import eth_rx_cls_pkg::*;
#(
   parameter logic [47:0] MY_MAC   = 48'h123456789ABC,
   parameter logic [31:0] MY_IP    = {8'd192, 8'd168, 8'd37, 8'd24},
   parameter logic [15:0] UDP_PORT = 16'd1234,
   parameter int          DELAY    = 101,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_res_n,
   input  logic [3:0]       i_mii_rx_data,
   input  logic             i_mii_rx_dv,
   output logic [3:0]       o_mii_rx_data,
   output logic             o_mii_rx_dv,
   output logic             o_arp_en,
   output logic             o_icmp_en,
   output logic             o_udp_en,
   output logic [CNT_W-1:0] o_cnt_arp,
   output logic [CNT_W-1:0] o_cnt_icmp,
   output logic [CNT_W-1:0] o_cnt_udp,
   output logic [CNT_W-1:0] o_cnt_drop
);

   state_t     state;
   logic [6:0] nib_idx;
   logic [4:0] pre_cnt;
   logic [3:0] prev_nib;
   cls_t       cand, cand_nx, flags, pub_cls;
   logic       mac_my, mac_bc, my_nx, bc_nx, sfd, pub_en;
   int         nidx;
   logic [4:0] dly_out;

   eth_nibble_delay #(.DEPTH(DELAY), .W(5)) u_delay (
      .clk     (i_clk),
      .rst_n   (i_res_n),
      .sample  ({i_mii_rx_dv, i_mii_rx_data}),
      .delayed (dly_out)
   );

   assign {o_mii_rx_dv, o_mii_rx_data} = dly_out;
   assign nidx = int'(nib_idx);
   assign sfd  = (prev_nib == 4'h5) && (i_mii_rx_data == 4'hD);

   // Unicast and broadcast MAC matches are tracked separately so a mix of both never passes.
   always_comb begin
      cand_nx = cand;
      my_nx   = mac_my;
      bc_nx   = mac_bc;
      if (nidx < MAC_OFS + 12) begin
         if (i_mii_rx_data != field_nib(MY_MAC, 6, nidx - MAC_OFS)) my_nx = 1'b0;
         if (i_mii_rx_data != 4'hF) bc_nx = 1'b0;
         if (nidx == MAC_OFS + 11) begin
            if (!my_nx) begin
               cand_nx.icmp = 1'b0;
               cand_nx.udp  = 1'b0;
            end
            if (!my_nx && !bc_nx) cand_nx.arp = 1'b0;
         end
      end
      if (nidx >= ETYPE_OFS && nidx < ETYPE_OFS + 4) begin
         if (i_mii_rx_data != field_nib(48'(ETYPE_ARP), 2, nidx - ETYPE_OFS)) cand_nx.arp = 1'b0;
         if (i_mii_rx_data != field_nib(48'(ETYPE_IPV4), 2, nidx - ETYPE_OFS)) begin
            cand_nx.icmp = 1'b0;
            cand_nx.udp  = 1'b0;
         end
      end
      if (nidx >= IHL_OFS && nidx < IHL_OFS + 2 &&
          i_mii_rx_data != field_nib(48'(IPV4_VIHL), 1, nidx - IHL_OFS)) begin
         cand_nx.icmp = 1'b0;
         cand_nx.udp  = 1'b0;
      end
      if (nidx >= PROTO_OFS && nidx < PROTO_OFS + 2) begin
         if (i_mii_rx_data != field_nib(48'(PROTO_ICMP), 1, nidx - PROTO_OFS)) cand_nx.icmp = 1'b0;
         if (i_mii_rx_data != field_nib(48'(PROTO_UDP), 1, nidx - PROTO_OFS)) cand_nx.udp = 1'b0;
      end
      if (nidx >= IPDST_OFS && nidx < IPDST_OFS + 8 &&
          i_mii_rx_data != field_nib(48'(MY_IP), 4, nidx - IPDST_OFS)) begin
         cand_nx.icmp = 1'b0;
         cand_nx.udp  = 1'b0;
      end
      if (nidx >= ICMPT_OFS && nidx < ICMPT_OFS + 2 &&
          i_mii_rx_data != field_nib(48'(ICMP_ECHO_REQ), 1, nidx - ICMPT_OFS)) cand_nx.icmp = 1'b0;
      if (nidx >= UDPDP_OFS && nidx < UDPDP_OFS + 4 &&
          i_mii_rx_data != field_nib(48'(UDP_PORT), 2, nidx - UDPDP_OFS)) cand_nx.udp = 1'b0;
      if (nidx >= ARPTIP_OFS && nidx < ARPTIP_OFS + 8 &&
          i_mii_rx_data != field_nib(48'(MY_IP), 4, nidx - ARPTIP_OFS)) cand_nx.arp = 1'b0;
   end

   // Publication: decision at the last checked nibble, or an all-zero drop on abort/timeout.
   always_comb begin
      pub_en  = 1'b0;
      pub_cls = '0;
      case (state)
         ST_PRE: if (!i_mii_rx_dv || (!sfd && pre_cnt == 5'(PRE_MAX - 1))) pub_en = 1'b1;
         ST_HDR: begin
            if (!i_mii_rx_dv) begin
               pub_en = 1'b1;
            end else if (nidx == DECIDE) begin
               pub_en  = 1'b1;
               pub_cls = cand_nx;
            end
         end
         default: pub_en = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         state    <= ST_IDLE;
         nib_idx  <= '0;
         pre_cnt  <= '0;
         prev_nib <= '0;
         cand     <= '0;
         mac_my   <= 1'b0;
         mac_bc   <= 1'b0;
         flags    <= '0;
      end else begin
         if (pub_en) flags <= pub_cls;
         case (state)
            ST_IDLE: begin
               if (i_mii_rx_dv) begin
                  state    <= ST_PRE;
                  prev_nib <= i_mii_rx_data;
                  pre_cnt  <= 5'd1;
               end
            end
            ST_PRE: begin
               if (!i_mii_rx_dv) begin
                  state <= ST_IDLE;
               end else if (sfd) begin
                  state   <= ST_HDR;
                  nib_idx <= '0;
                  cand    <= '1;
                  mac_my  <= 1'b1;
                  mac_bc  <= 1'b1;
               end else if (pre_cnt == 5'(PRE_MAX - 1)) begin
                  state <= ST_DONE;
               end else begin
                  pre_cnt  <= pre_cnt + 5'd1;
                  prev_nib <= i_mii_rx_data;
               end
            end
            ST_HDR: begin
               if (!i_mii_rx_dv) begin
                  state <= ST_IDLE;
               end else begin
                  cand    <= cand_nx;
                  mac_my  <= my_nx;
                  mac_bc  <= bc_nx;
                  nib_idx <= nib_idx + 7'd1;
                  if (nidx == DECIDE) state <= ST_DONE;
               end
            end
            ST_DONE: if (!i_mii_rx_dv) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_arp_en  = flags.arp;
   assign o_icmp_en = flags.icmp;
   assign o_udp_en  = flags.udp;

`ifdef ETH_RX_CLS_STATS_EN
   logic [CNT_W-1:0] cnt_arp, cnt_icmp, cnt_udp, cnt_drop;

   // Saturating counters advance on the same edge that publishes the flags.
   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         cnt_arp  <= '0;
         cnt_icmp <= '0;
         cnt_udp  <= '0;
         cnt_drop <= '0;
      end else if (pub_en) begin
         if (pub_cls.arp && cnt_arp != '1) cnt_arp <= cnt_arp + CNT_W'(1);
         if (pub_cls.icmp && cnt_icmp != '1) cnt_icmp <= cnt_icmp + CNT_W'(1);
         if (pub_cls.udp && cnt_udp != '1) cnt_udp <= cnt_udp + CNT_W'(1);
         if (pub_cls == '0 && cnt_drop != '1) cnt_drop <= cnt_drop + CNT_W'(1);
      end
   end

   assign o_cnt_arp  = cnt_arp;
   assign o_cnt_icmp = cnt_icmp;
   assign o_cnt_udp  = cnt_udp;
   assign o_cnt_drop = cnt_drop;
`else
   assign o_cnt_arp  = '0;
   assign o_cnt_icmp = '0;
   assign o_cnt_udp  = '0;
   assign o_cnt_drop = '0;
`endif

endmodule

// File: doc/eth_rx_classifier.md
# eth_rx_classifier

MII receive-side frame classifier and delay line, the parametrised successor of the fixed-offset ARP/ICMP splitter. It locks onto the SFD rather than a fixed nibble count, checks the MAC, IPv4 and protocol fields against parameters, and flags each frame as ARP, ICMP echo or UDP-to-port. It delays the nibble stream so the flags are stable before the frame reaches the ARP, ICMP and UDP responders downstream.

## Interface
- MY_MAC, 48'h123456789ABC, station MAC address.
- MY_IP, {8'd192,8'd168,8'd37,8'd24}, station IPv4 address.
- UDP_PORT, 16'd1234, accepted UDP destination port.
- DELAY, 101, delay line length in nibbles; legal range is 101 to 4095.
- CNT_W, 16, width of each statistics counter.
- i_clk  in  1  MII RX clock; the block has one clock.
- i_res_n  in  1  asynchronous active-low reset.
- i_mii_rx_data  in  4  RX nibble, low nibble of each byte first.
- i_mii_rx_dv  in  1  RX data valid.
- o_mii_rx_data  out  4  i_mii_rx_data delayed by DELAY cycles.
- o_mii_rx_dv  out  1  i_mii_rx_dv delayed by DELAY cycles.
- o_arp_en, o_icmp_en, o_udp_en  out  1 each  class flags, at most one high at a time.
- o_cnt_arp, o_cnt_icmp, o_cnt_udp, o_cnt_drop  out  CNT_W each  saturating frame counters.

## Operation
- Reset value of every output is 0; the delay line contents are also 0.
- States:
  - IDLE: while dv is low.
  - PRE: on dv rise; waits for nibble 5 immediately followed by nibble D (the SFD).
  - HDR: frame nibble index n runs 0..83, where n=0 is the first nibble after the SFD.
  - DONE: holds until dv falls, then returns to IDLE.
- PRE timeout: no SFD within 24 nibbles goes to DONE as a drop.
- dv low in any state returns to IDLE. If this happens in PRE or HDR, the frame is published as a drop.
- Checks, per nibble index n:
  - Destination MAC, n=0..11: must equal MY_MAC. ARP also accepts all-F (broadcast).
  - EtherType, n=24..27: 0806 for ARP, 0800 for IPv4.
  - IPv4 version/IHL byte, n=28..29: must be 0x45.
  - IPv4 protocol, n=46..47: 01 for ICMP, 11 for UDP.
  - IPv4 destination address, n=60..67: must equal MY_IP, for ICMP and UDP.
  - ICMP type, n=68..69: must be 08.
  - UDP destination port, n=72..75: must equal UDP_PORT.
  - ARP target IP, n=76..83: must equal MY_IP.
- Each check clears its candidate bit (arp/icmp/udp). All three candidates are set on SFD detection.
- Decision point is n=83 in HDR, entering DONE. The surviving candidate bits are registered onto the o_*_en flags.
- If no candidate survives, or the frame is published as a drop, all flags go to 0.
- Flags are held until the next frame's publication.

## Timing
- Flags change exactly once per frame, on the cycle after the nibble at n=83 (or after the abort/timeout condition).
- The output stream lags the input by exactly DELAY cycles, independent of state.
- With a preamble+SFD of P nibbles, flags are stable at o_mii_rx_dv rise when P ≤ DELAY−85. With DELAY=101 this covers the standard P=16.
- Flag publication for frame k+1 never overlaps output of frame k, given an inter-frame gap of at least 24 nibbles and DELAY ≤ P+108.
- Counters increment on the publication cycle. o_cnt_drop counts frames published with all flags 0. Counters saturate at all-ones.
- Asynchronous reset mid-frame: the FSM returns to IDLE and flags and counters clear. The remainder of the in-progress frame is treated as a PRE timeout or abort and counts as a drop.

## Configuration
- ETH_RX_CLS_STATS_EN defined: the four counters are implemented as above.
- ETH_RX_CLS_STATS_EN undefined: the counter ports are still present but tied to 0, and no counter flops are built.

## Structure
- Package eth_rx_cls_pkg holds:
  - the FSM state enum;
  - the nibble-offset constants (MAC, ETYPE, IHL, PROTO, IPDST, ICMPT, UDPDP, ARPTIP, DECIDE=83);
  - the EtherType constants (0x0806, 0x0800) and protocol constants (0x01, 0x11).
- Sub-module eth_nibble_delay (parameters DEPTH and W=5) implements the data+dv shift line.

## Test plan
- ARP request: P=16, broadcast destination, target IP 192.168.37.24 -> o_arp_en=1 before o_mii_rx_dv rises; o_cnt_arp=1.
- ICMP echo: destination MY_MAC and MY_IP, type 08 -> o_icmp_en=1 and the other flags 0. Repeat with type 00 -> all flags 0, o_cnt_drop=1.
- UDP: destination port 1234 -> o_udp_en=1. Repeat with port 1235 -> drop. Repeat with broadcast MAC -> drop.
- Preamble lengths: P=10 and P=16 with the same ARP frame -> identical flags; output lag exactly 101 cycles.
- Runt frame: dv falls at n=40 -> flags 0 on the next cycle; FSM in IDLE. No SFD for 24 nibbles -> drop.
- Reset asserted at n=50 of an ICMP frame -> all outputs 0. The next valid ARP frame classifies correctly.
